// File: rtl/grid_cursor.sv
// -----------------------------------------------------------------------------
// grid_cursor
//
// Tile-cursor controller for the VGA grid.
//
// Debounced direction levels from the keyboard decoder move a registered
// (curh, curv) tile position. A held key produces a move immediately, a second
// move after REPEAT_DELAY cycles, and further moves every REPEAT_RATE cycles.
// Each axis steps independently, so diagonal moves are allowed.
//
// Optional feature macro: GRID_CURSOR_WRAP_EN
//   defined     - a step past an edge wraps to the opposite edge; bump stays 0
//   not defined - a step past an edge is clamped and reported on bump
//
// Ports
//   clk    in   system clock
//   rst    in   asynchronous, active-low reset
//   up     in   direction level (down has priority)
//   down   in   direction level
//   left   in   direction level (left has priority over right)
//   right  in   direction level
//   home   in   jump to (HOME_H, HOME_V); FSM returns to IDLE
//   lock   in   freezes position, FSM and timer; beats home and directions
//   curh   out  current column (HW bits), registered
//   curv   out  current row (VW bits), registered
//   moved  out  one-cycle pulse after the position changed
//   bump   out  one-cycle pulse after a requested step hit an edge
//   busy   out  FSM is in HOLD or REPEAT
// -----------------------------------------------------------------------------
module grid_cursor #(
    parameter int H_TILES      = 10,
    parameter int V_TILES      = 6,
    parameter int HW           = 4,
    parameter int VW           = 3,
    parameter int HOME_H       = 0,
    parameter int HOME_V       = 0,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 6250000,
    parameter int CNT_W        = 25
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up,
    input  logic          down,
    input  logic          left,
    input  logic          right,
    input  logic          home,
    input  logic          lock,
    output logic [HW-1:0] curh,
    output logic [VW-1:0] curv,
    output logic          moved,
    output logic          bump,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    localparam logic [HW-1:0]    H_MAX     = HW'(H_TILES - 1);
    localparam logic [VW-1:0]    V_MAX     = VW'(V_TILES - 1);
    localparam logic [HW-1:0]    H_HOME    = HW'(HOME_H);
    localparam logic [VW-1:0]    V_HOME    = VW'(HOME_V);
    localparam logic [CNT_W-1:0] DELAY_END = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_END  = CNT_W'(REPEAT_RATE - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] timer;
    logic [3:0]       req;
    logic [3:0]       last_req;

    logic [HW-1:0]    step_h;
    logic [VW-1:0]    step_v;
    logic             blocked;
    logic             step_moved;

    logic             do_step;
    logic             timer_clr;
    logic             timer_inc;
    logic             load_last;

    // Resolved request: {left, right, down, up} with left/down winning their axis.
    assign req = {left, right & ~left, down, up & ~down};

    // Candidate position for a step; edges compare before any +/-1 so the
    // arithmetic never leaves the legal tile range.
    always_comb begin
        step_h  = curh;
        step_v  = curv;
        blocked = 1'b0;
        if (req[3]) begin
            if (curh == '0) begin
`ifdef GRID_CURSOR_WRAP_EN
                step_h = H_MAX;
`else
                blocked = 1'b1;
`endif
            end else begin
                step_h = curh - 1'b1;
            end
        end else if (req[2]) begin
            if (curh == H_MAX) begin
`ifdef GRID_CURSOR_WRAP_EN
                step_h = '0;
`else
                blocked = 1'b1;
`endif
            end else begin
                step_h = curh + 1'b1;
            end
        end
        if (req[1]) begin
            if (curv == V_MAX) begin
`ifdef GRID_CURSOR_WRAP_EN
                step_v = '0;
`else
                blocked = 1'b1;
`endif
            end else begin
                step_v = curv + 1'b1;
            end
        end else if (req[0]) begin
            if (curv == '0) begin
`ifdef GRID_CURSOR_WRAP_EN
                step_v = V_MAX;
`else
                blocked = 1'b1;
`endif
            end else begin
                step_v = curv - 1'b1;
            end
        end
    end

    assign step_moved = (step_h != curh) || (step_v != curv);

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state; lock freezes it, home forces IDLE
    always_comb begin
        state_nxt = state;
        if (!lock) begin
            if (home) begin
                state_nxt = IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (req != '0) state_nxt = HOLD;
                    end
                    HOLD: begin
                        if (req == '0)                  state_nxt = IDLE;
                        else if (req != last_req)       state_nxt = HOLD;
                        else if (timer == DELAY_END)    state_nxt = REPEAT;
                    end
                    REPEAT: begin
                        if (req == '0)                  state_nxt = IDLE;
                        else if (req != last_req)       state_nxt = HOLD;
                    end
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    // FSM outputs: step strobe and timer / last_req controls
    always_comb begin
        do_step   = 1'b0;
        timer_clr = 1'b0;
        timer_inc = 1'b0;
        load_last = 1'b0;
        if (!lock) begin
            if (home) begin
                timer_clr = 1'b0 | 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (req != '0) begin
                            do_step   = 1'b1;
                            timer_clr = 1'b1;
                            load_last = 1'b1;
                        end
                    end
                    HOLD, REPEAT: begin
                        if (req == '0) begin
                            timer_clr = 1'b1;
                        end else if (req != last_req) begin
                            // A different key combination counts as a fresh press
                            do_step   = 1'b1;
                            timer_clr = 1'b1;
                            load_last = 1'b1;
                        end else if (timer == ((state == HOLD) ? DELAY_END : RATE_END)) begin
                            do_step   = 1'b1;
                            timer_clr = 1'b1;
                        end else begin
                            timer_inc = 1'b1;
                        end
                    end
                    default: timer_clr = 1'b1;
                endcase
            end
        end
    end

    assign busy = (state != IDLE);

    // Position, timer and event pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            curh     <= H_HOME;
            curv     <= V_HOME;
            timer    <= '0;
            last_req <= '0;
            moved    <= 1'b0;
            bump     <= 1'b0;
        end else begin
            moved <= 1'b0;
            bump  <= 1'b0;
            if (!lock) begin
                if (home) begin
                    curh  <= H_HOME;
                    curv  <= V_HOME;
                    moved <= (curh != H_HOME) || (curv != V_HOME);
                end else if (do_step) begin
                    curh  <= step_h;
                    curv  <= step_v;
                    moved <= step_moved;
                    bump  <= blocked;
                end
            end
            if (timer_clr) begin
                timer <= '0;
            end else if (timer_inc) begin
                timer <= timer + 1'b1;
            end
            if (load_last) begin
                last_req <= req;
            end
        end
    end

endmodule

// File: doc/grid_cursor.md
Name: grid_cursor

Overview:
Parametrised tile-cursor controller for the VGA grid. It is the successor of the fixed 10x6 single-step player cursor. It takes debounced direction levels from the keyboard decoder and produces the registered tile coordinates consumed by the VGA tile renderer. Compared with the fixed cursor it adds:
- configurable grid size and counter widths
- a press / hold-delay / auto-repeat state machine
- diagonal moves, a home command and a lock input
- move and edge-bump pulses for the sound and score logic

Parameters:
H_TILES, 10, number of horizontal tiles; legal range 2..256.
V_TILES, 6, number of vertical tiles; legal range 2..256.
HW, 4, curh width; must satisfy 2^HW >= H_TILES.
VW, 3, curv width; must satisfy 2^VW >= V_TILES.
HOME_H, 0, column loaded by reset and by home.
HOME_V, 0, row loaded by reset and by home.
REPEAT_DELAY, 25000000, cycles from the first move to the first auto-repeat move; must be >= 2.
REPEAT_RATE, 6250000, cycles between auto-repeat moves; must be >= 1.
CNT_W, 25, timer width; must satisfy 2^CNT_W > max(REPEAT_DELAY, REPEAT_RATE).

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-low
up  in  1  direction level, synchronous to clk
down  in  1  direction level
left  in  1  direction level
right  in  1  direction level
home  in  1  synchronous request to jump to (HOME_H, HOME_V)
lock  in  1  when 1, freezes position, FSM and timer
curh  out  HW  current column, registered
curv  out  VW  current row, registered
moved  out  1  one-cycle pulse, 1 in the cycle after curh or curv changed
bump  out  1  one-cycle pulse, 1 in the cycle after a requested step was blocked at an edge
busy  out  1  1 when FSM is in HOLD or REPEAT

Behaviour:
- Reset (rst=0, asynchronous): curh=HOME_H, curv=HOME_V, FSM=IDLE, timer=0, moved=0, bump=0.
- Request vector req is resolved combinationally each cycle:
  - Horizontal: left has priority over right.
  - Vertical: down has priority over up.
  - One step per axis, so diagonal steps are allowed.
  - req=0 when no key is pressed.
- A "step" updates curh/curv on the current edge. The same edge sets moved/bump, so they are visible for the following cycle only.
- FSM states IDLE, HOLD, REPEAT. The last-applied req is held in register last_req.
- IDLE:
  - req!=0: step, last_req=req, timer=0, go to HOLD.
- HOLD:
  - req==0: go to IDLE.
  - req!=last_req: step, restart timer, stay in HOLD.
  - timer==REPEAT_DELAY-1: step, timer=0, go to REPEAT.
  - Otherwise: timer+1.
- REPEAT:
  - req==0: go to IDLE.
  - req!=last_req: step, timer=0, go to HOLD.
  - timer==REPEAT_RATE-1: step, timer=0.
  - Otherwise: timer+1.
- Net effect: with a held key, moves occur at edges e0, e0+REPEAT_DELAY, then every REPEAT_RATE edges.
- Edge handling without wrap: a step at column 0 left, column H_TILES-1 right, row 0 up, or row V_TILES-1 down leaves that axis unchanged.
  - bump=1 if any requested axis was blocked.
  - moved=1 only if the other axis actually changed.
  - bump and moved may both be 1 on the same diagonal step.
- home=1:
  - Has priority over directions.
  - Loads HOME_H/HOME_V; moved=1 only if the position differs.
  - FSM goes to IDLE, timer=0.
  - Directions held through and after home release count as a new press.
- lock=1:
  - Has priority over home and directions.
  - All state is held; moved=0, bump=0.
  - On release, the FSM resumes from its held state and timer value.
- Arithmetic is unsigned and sized to HW/VW. No intermediate value may exceed H_TILES-1 or V_TILES-1.
- busy = (FSM != IDLE).

Optional Feature:
GRID_CURSOR_WRAP_EN
- Defined: a step past an edge wraps to the opposite edge (column 0 left goes to H_TILES-1, row V_TILES-1 down goes to 0, and so on). Wrapping counts as a change, so moved=1. bump is tied to 0.
- Not defined: clamping and bump behave as described in Behaviour.

Test Plan:
- Reset: H_TILES=10, V_TILES=6, REPEAT_DELAY=4, REPEAT_RATE=2, rst low for 3 cycles -> curh=0, curv=0, moved=0, bump=0, busy=0.
- Press and repeat: hold right from edge e0 -> curh=1 after e0, 2 after e0+4, 3 after e0+6, 4 after e0+8; moved high exactly one cycle after each of these edges.
- Change while held: hold right, then switch to down at e0+2 -> curv=1 after e0+2; next move at e0+6, not e0+4.
- Clamp (wrap macro undefined): from curh=9, hold right + down -> curh stays 9, curv 0->1, bump=1 and moved=1 in the same cycle.
- Wrap (GRID_CURSOR_WRAP_EN defined): from curh=0, press left -> curh=9, moved=1, bump=0.
- Lock and home: hold left from curh=5, assert lock for 10 cycles -> curh stays 5 and the timer holds its value. Then assert home with lock=0 -> curh=0, curv=0, busy=0 in the cycle after.
